// File: rtl/exp2_pipe_unit.sv
// exp2_pipe_unit: pipelined multi-lane piecewise-linear 2^x.
// S1 splits x into integer/fraction and latches K/B from the shared LUT,
// S2 forms the K*frac+B mantissa, S3 applies the integer part as a shift
// with saturation. All stages advance together on a single enable.

module exp2_lane #(
   parameter int WIDTH    = 32,
   parameter int Q_IN     = 22,
   parameter int Q_OUT    = 16,
   parameter int SEG_BITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [WIDTH-1:0]      x,
   input  logic [WIDTH-1:0]      k,
   input  logic [WIDTH-1:0]      b,
   output logic [SEG_BITS-1:0]   seg,
   output logic [2*WIDTH-1:0]    y,
   output logic                  sat
);
   localparam int W2 = 2 * WIDTH;
   localparam int SH = $clog2(W2);
   localparam logic [WIDTH-1:0] W2_U = WIDTH'(W2);

   logic signed [WIDTH-1:0] s1_int, s1_k, s1_b, s2_int;
   logic        [Q_IN-1:0]  s1_frac;
   logic signed [W2-1:0]    s2_mant;
   logic signed [W2-1:0]    prod, shl, y_n;
   logic signed [WIDTH-1:0] mant, mant_q;
   logic        [WIDTH-1:0] nsh;
   logic                    sat_n;

   // segment index comes straight from the top fraction bits of the input
   assign seg = x[Q_IN-1 -: SEG_BITS];

   // S1: integer/fraction split, K/B latched so stalls never re-read the LUT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_int  <= '0;
         s1_frac <= '0;
         s1_k    <= '0;
         s1_b    <= '0;
      end else if (en) begin
         s1_int  <= $signed(x) >>> Q_IN;
         s1_frac <= x[Q_IN-1:0];
         s1_k    <= k;
         s1_b    <= b;
      end
   end

   // mantissa: signed slope times unsigned fraction, plus intercept, requantised
   always_comb begin
      prod   = W2'(s1_k) * $signed({{(W2-Q_IN){1'b0}}, s1_frac});
      mant   = WIDTH'(prod >>> Q_IN) + s1_b;
      mant_q = mant >>> (Q_IN - Q_OUT);
   end

   // S2: sign-extended mantissa and integer part
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_int  <= '0;
         s2_mant <= '0;
      end else if (en) begin
         s2_int  <= s1_int;
         s2_mant <= {{WIDTH{mant_q[WIDTH-1]}}, mant_q};
      end
   end

   // shift by the integer part; left shifts that lose bits saturate
   always_comb begin
      nsh   = -s2_int;
      shl   = s2_mant << s2_int[SH-1:0];
      y_n   = shl;
      sat_n = 1'b0;
      if (!s2_int[WIDTH-1]) begin
         if ($unsigned(s2_int) >= W2_U || (shl >>> s2_int[SH-1:0]) != s2_mant) begin
            sat_n = 1'b1;
            y_n   = s2_mant[W2-1] ? {1'b1, {(W2-1){1'b0}}} : {1'b0, {(W2-1){1'b1}}};
         end
      end else if (nsh >= W2_U) begin
         y_n = {W2{s2_mant[W2-1]}};
      end else begin
         y_n = s2_mant >>> nsh[SH-1:0];
      end
   end

   // S3: output register, held while the pipe is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y   <= '0;
         sat <= 1'b0;
      end else if (en) begin
         y   <= y_n;
         sat <= sat_n;
      end
   end
endmodule

module exp2_pipe_unit #(
   parameter int WIDTH    = 32,
   parameter int Q_IN     = 22,
   parameter int Q_OUT    = 16,
   parameter int SEG_BITS = 3,
   parameter int LANES    = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*WIDTH-1:0]     in_x,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*2*WIDTH-1:0]   out_y,
   output logic [LANES-1:0]           out_sat,
   input  logic                       lut_we,
   input  logic [SEG_BITS-1:0]        lut_addr,
   input  logic [WIDTH-1:0]           lut_k,
   input  logic [WIDTH-1:0]           lut_b
);
   localparam int NSEG = 2 ** SEG_BITS;

   logic                             en;
   logic [3:1]                       vld_pipe;
   logic [WIDTH-1:0]                 lut_k_r [NSEG];
   logic [WIDTH-1:0]                 lut_b_r [NSEG];
   logic [LANES-1:0][SEG_BITS-1:0]   seg;

   // one global enable; bubbles travel with the beats rather than collapsing
   assign en        = ~vld_pipe[3] | out_ready;
   assign in_ready  = en;
   assign out_valid = vld_pipe[3];

   // valid shift register tracks which stages hold real beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  vld_pipe <= '0;
      else if (en) vld_pipe <= {vld_pipe[2:1], in_valid};
   end

   // shared K/B table; a write lands on the edge, so same-cycle S1 reads see old data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSEG; i++) begin
            lut_k_r[i] <= '0;
            lut_b_r[i] <= '0;
         end
      end else if (lut_we) begin
         lut_k_r[lut_addr] <= lut_k;
         lut_b_r[lut_addr] <= lut_b;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      exp2_lane #(
         .WIDTH(WIDTH), .Q_IN(Q_IN), .Q_OUT(Q_OUT), .SEG_BITS(SEG_BITS)
      ) u_lane (
         .clk  (clk),
         .rst_n(rst_n),
         .en   (en),
         .x    (in_x[l*WIDTH +: WIDTH]),
         .k    (lut_k_r[seg[l]]),
         .b    (lut_b_r[seg[l]]),
         .seg  (seg[l]),
         .y    (out_y[l*2*WIDTH +: 2*WIDTH]),
         .sat  (out_sat[l])
      );
   end
endmodule

// File: tb/tb_exp2_pipe_unit.sv
// Scoreboard bench for exp2_pipe_unit: expected beats are queued on
// acceptance and compared as they leave the pipe.

module tb_exp2_pipe_unit;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, lut_we;
   logic [127:0] in_x;
   logic [255:0] out_y;
   logic [3:0]   out_sat;
   logic [2:0]   lut_addr;
   logic [31:0]  lut_k, lut_b;

   int n_cmp = 0, n_err = 0, n_acc = 0, n_out = 0;
   logic [255:0] q_y [$];
   logic [3:0]   q_s [$];
   logic [31:0]  sk [8];
   logic [31:0]  sb [8];

   exp2_pipe_unit dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sat(out_sat),
      .lut_we(lut_we), .lut_addr(lut_addr), .lut_k(lut_k), .lut_b(lut_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] pk4(input logic [31:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic logic [255:0] pky(input logic [63:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   // reference: exact integer arithmetic, overflow judged by range of mant*2^s
   function automatic void model(input logic [31:0] x, output logic [63:0] y, output logic s);
      logic signed [31:0]  xs, k, b, m;
      logic [21:0]         fr;
      longint              p, mm;
      logic signed [127:0] big;
      int                  sh;
      xs = x;
      sh = int'(xs >>> 22);
      fr = x[21:0];
      k  = sk[fr[21:19]];
      b  = sb[fr[21:19]];
      p  = longint'(k) * longint'({10'b0, fr});
      m  = 32'(p >>> 22) + b;
      m  = m >>> 6;
      mm = longint'(m);
      s  = 1'b0;
      if (sh >= 0) begin
         if (sh >= 64) s = 1'b1;
         else begin
            big = 128'(mm) * (128'sd1 <<< sh);
            if (big > 128'sh7FFF_FFFF_FFFF_FFFF || big < -128'sh8000_0000_0000_0000) s = 1'b1;
            y = big[63:0];
         end
         if (s) y = (mm < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
      end else if (-sh >= 64) begin
         y = (mm < 0) ? '1 : '0;
      end else begin
         y = 64'(mm >>> (-sh));
      end
   endfunction

   task automatic lut_wr(input int a, input logic [31:0] k, input logic [31:0] b);
      lut_we = 1'b1; lut_addr = 3'(a); lut_k = k; lut_b = b;
      @(posedge clk); #1;
      lut_we = 1'b0;
      sk[a] = k; sb[a] = b;
   endtask

   // offer one beat; the expectation is queued in the cycle it is accepted
   task automatic send(input logic [127:0] x, input logic [255:0] ey, input logic [3:0] es);
      int t;
      in_x = x; in_valid = 1'b1; t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("in_timeout", 0, 1);
      else begin
         q_y.push_back(ey); q_s.push_back(es); n_acc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [127:0] x);
      logic [255:0] ey;
      logic [3:0]   es;
      logic [63:0]  y1;
      logic         s1;
      for (int l = 0; l < 4; l++) begin
         model(x[l*32 +: 32], y1, s1);
         ey[l*64 +: 64] = y1;
         es[l] = s1;
      end
      send(x, ey, es);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (q_y.size() != 0 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain", 256'(q_y.size()), 0);
   endtask

   // output side of the scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         if (q_y.size() == 0) chk("unexpected_out", 1, 0);
         else begin
            chk("y", out_y, q_y.pop_front());
            chk("sat", 256'(out_sat), 256'(q_s.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] xv [4];
      int          s, base;
      rst_n = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
      lut_we = 1'b0; lut_addr = '0; lut_k = '0; lut_b = '0;
      for (int i = 0; i < 8; i++) begin sk[i] = '0; sb[i] = '0; end
      #12;
      chk("rst_out_valid", 256'(out_valid), 0);
      chk("rst_in_ready", 256'(in_ready), 1);
      chk("rst_out_y", out_y, 0);
      chk("rst_out_sat", 256'(out_sat), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // flat table 1.0: pure powers of two, and latency
      for (int i = 0; i < 8; i++) lut_wr(i, 32'h0, 32'h0040_0000);
      send(pk4(32'h00C0_0000, 32'hFF80_0000, 32'h0, 32'h0040_0000),
           pky(64'h80000, 64'h4000, 64'h10000, 64'h20000), 4'b0000);
      @(posedge clk); #1;
      chk("lat_early", 256'(out_valid), 0);
      @(posedge clk); #1;
      chk("lat_valid", 256'(out_valid), 1);
      wait_drain();

      // linear segment 4 evaluated at 0.5
      lut_wr(4, 32'h0040_0000, 32'h0040_0000);
      send(pk4(32'h0020_0000, 0, 0, 0), pky(64'h18000, 64'h10000, 64'h10000, 64'h10000), 4'b0000);
      // same-edge write to the entry being read: old K/B must be used
      lut_we = 1'b1; lut_addr = 3'd4; lut_k = 32'h0; lut_b = 32'h0080_0000;
      send(pk4(32'h0020_0000, 0, 0, 0), pky(64'h18000, 64'h10000, 64'h10000, 64'h10000), 4'b0000);
      lut_we = 1'b0; sk[4] = 32'h0; sb[4] = 32'h0080_0000;
      send(pk4(32'h0020_0000, 0, 0, 0), pky(64'h20000, 64'h10000, 64'h10000, 64'h10000), 4'b0000);

      // saturation with positive mantissa, deep underflow
      send(pk4(32'h0F00_0000, 32'hE700_0000, 32'h03C0_0000, 32'h0BC0_0000),
           pky(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000, 64'h7FFF_FFFF_FFFF_FFFF), 4'b1001);
      // negative mantissa: exact -2^63 fits, one more bit saturates low
      lut_wr(0, 32'h0, 32'hFFC0_0000);
      send(pk4(32'h0BC0_0000, 32'h0C00_0000, 32'hEE80_0000, 32'hFFC0_0000),
           pky(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_8000), 4'b0010);
      wait_drain();

      // random table and random inputs, back to back
      for (int i = 0; i < 8; i++) lut_wr(i, $urandom, $urandom);
      for (int n = 0; n < 12; n++) begin
         for (int l = 0; l < 4; l++) begin
            s = int'($urandom_range(140)) - 70;
            xv[l] = {s[9:0], 22'($urandom)};
         end
         send_m(pk4(xv[0], xv[1], xv[2], xv[3]));
      end
      wait_drain();

      // backpressure: 3 beats fill the pipe, the rest wait, order preserved
      out_ready = 1'b0;
      base = n_acc;
      fork
         begin
            for (int n = 0; n < 5; n++)
               send_m(pk4(32'((n + 1) << 22) | 32'h0012_3456, 32'(n << 19),
                          32'hFFE0_0000 - 32'(n << 20), 32'(n * 32'h0150_0000)));
         end
         begin
            repeat (8) @(posedge clk);
            #2;
            chk("stall_accepted", 256'(n_acc - base), 3);
            chk("stall_in_ready", 256'(in_ready), 0);
            chk("stall_out_valid", 256'(out_valid), 1);
            chk("stall_hold_y", out_y, q_y[0]);
            repeat (3) @(posedge clk);
            #2;
            chk("stall_hold_y2", out_y, q_y[0]);
            chk("stall_hold_sat", 256'(out_sat), 256'(q_s[0]));
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // reset with beats in flight
      out_ready = 1'b0;
      send_m(pk4(32'h0040_0000, 32'h0080_0000, 0, 32'hFFC0_0000));
      send_m(pk4(32'h00C0_0000, 0, 32'h0040_0000, 0));
      @(posedge clk); #1;
      chk("pre_rst_valid", 256'(out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 256'(out_valid), 0);
      chk("rst_mid_y", out_y, 0);
      n_acc -= q_y.size();
      q_y.delete(); q_s.delete();
      for (int i = 0; i < 8; i++) begin sk[i] = '0; sb[i] = '0; end
      @(posedge clk); #3;
      rst_n = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         chk("no_stale", 256'(out_valid), 0);
         @(posedge clk); #1;
      end
      // cleared table gives zero everywhere
      send(pk4(32'h00C0_0000, 32'hFF80_0000, 32'h0020_0000, 32'h0040_0000), 0, 4'b0000);
      wait_drain();

      chk("out_count", 256'(n_out), 256'(n_acc));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/exp2_pipe_unit.md
Name: exp2_pipe_unit

Overview:
- Pipelined, multi-lane successor to the combinational piecewise-linear 2^x exponent unit used in the GELU datapath.
- Computes 2^x for LANES fixed-point inputs per beat: integer/fraction split, segment LUT lookup, K*frac+B mantissa, barrel shift, saturation.
- Owns a runtime-loadable K/B LUT shared by all lanes; valid/ready streaming on input and output.
- Sits between the GELU argument-scaling stage and the reciprocal/normalisation stage.

Parameters:
- WIDTH, 32, input/LUT word width; signed fixed point Q(WIDTH-Q_IN).Q_IN.
- Q_IN, 22, fractional bits of inputs and K/B.
- Q_OUT, 16, fractional bits of the 2*WIDTH-bit output.
- SEG_BITS, 3, LUT index width; 2**SEG_BITS segments taken from the top fraction bits.
- LANES, 4, parallel lanes per beat.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts a beat this cycle
- in_x  in  LANES*WIDTH  packed signed inputs, lane 0 in LSBs
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_y  out  LANES*2*WIDTH  packed signed Q(2W-Q_OUT).Q_OUT results
- out_sat  out  LANES  per-lane overflow saturation flag
- lut_we  in  1  LUT write strobe
- lut_addr  in  SEG_BITS  LUT entry
- lut_k  in  WIDTH  slope, Q_IN fraction
- lut_b  in  WIDTH  intercept, Q_IN fraction

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0, out_valid=0, out_y=0, out_sat=0, all LUT K/B=0. in_ready=1 after reset.
- Global advance en = ~out_valid | out_ready. in_ready = en. A beat is taken when in_valid & in_ready. All three stages shift together on en; bubbles are not collapsed.
- Latency: 3 cycles from acceptance to out_valid under en=1. Beats exit in order. out_y/out_sat are held stable while out_valid & ~out_ready.
- S1 (register): per lane s_int = x >>> Q_IN (signed), s_frac = x[Q_IN-1:0], seg = s_frac[Q_IN-1 -: SEG_BITS]. K and B are captured from LUT[seg].
- S2 (register): full product = K * zero-extended s_frac (2*WIDTH). mant = (product >>> Q_IN) + B, truncated to WIDTH. mant_q = mant >>> (Q_IN-Q_OUT). Then sign-extend to 2*WIDTH. s_int is carried along.
- S3 (register), s_int >= 0:
  - y = mant64 << s_int.
  - Overflow when (y >>> s_int) != mant64 or s_int >= 2*WIDTH.
  - On overflow: y = 2**(2W-1)-1 if mant64 >= 0, else -2**(2W-1), and sat=1.
- S3 (register), s_int < 0:
  - y = mant64 >>> (-s_int).
  - If -s_int >= 2*WIDTH: y = all sign bits (0 for non-negative mantissa).
  - sat=0.
- LUT write: a write takes effect at the next clk edge. An S1 capture in the same cycle as a write to the same entry reads the old value. Writes are allowed during streaming and while stalled; a stall does not re-read the LUT, because K/B are already registered.
- Reset mid-stream discards all in-flight beats. No output appears for them.

Test Plan:
- All 8 entries K=0, B=0x00400000. Lane inputs 0x00C00000 (3.0), 0xFF800000 (-2.0), 0, 0x00400000 -> after 3 cycles y = 0x80000, 0x4000, 0x10000, 0x20000; sat=0.
- Entry 4 K=0x00400000, B=0x00400000; x=0x00200000 (0.5, seg 4) -> y=0x18000 (1.5). Same entry written on the same cycle as S1 capture -> the old value is used.
- K=0, B=1.0; x=60.0 (0x0F000000) -> y=0x7FFFFFFFFFFFFFFF, sat=1. x=-100.0 -> y=0, sat=0.
- out_ready=0 while 5 beats are offered -> 3 accepted, then in_ready=0. out_y is held. Release out_ready -> all 5 beats emerge in order with no loss or duplication.
- rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately; LUT reads 0; no stale output after release.
